// File: rtl/cpu_debug_slave_sysclk_queue.sv
// rtl/cpu_debug_slave_sysclk_queue.sv - system-clock side of the JTAG debug slave with a capture queue
module cpu_debug_slave_sysclk_queue #(
   parameter int SR_W       = 38,
   parameter int IR_W       = 2,
   parameter int SYNC_DEPTH = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int ACT_BIT    = 35
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [SR_W-1:0]                 sr,
   input  logic [IR_W-1:0]                 ir_in,
   input  logic                            vs_udr,
   input  logic                            vs_uir,
   input  logic                            cmd_ready,
   input  logic                            overflow_clr,
   output logic                            cmd_valid,
   output logic [SR_W-1:0]                 jdo,
   output logic [(2**IR_W)-1:0]            take_action,
   output logic [(2**IR_W)-1:0]            take_no_action,
   output logic                            ir_update,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = IR_W + SR_W;

   logic [SYNC_DEPTH-1:0] udr_sync, uir_sync;
   logic                  udr_prev, uir_prev;
   logic                  udr_pulse, uir_pulse;

   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [EW-1:0]         head;
   logic                  full, push, pop, drop;
   logic                  pop_pend;
   logic [IR_W-1:0]       pop_ir;

   // Edge-detect flops reset to 0 so a strobe already high at reset release still fires once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_prev <= 1'b0;
         uir_prev <= 1'b0;
      end else begin
         udr_sync <= {udr_sync[SYNC_DEPTH-2:0], vs_udr};
         uir_sync <= {uir_sync[SYNC_DEPTH-2:0], vs_uir};
         udr_prev <= udr_sync[SYNC_DEPTH-1];
         uir_prev <= uir_sync[SYNC_DEPTH-1];
      end
   end

   assign udr_pulse = udr_sync[SYNC_DEPTH-1] & ~udr_prev;
   assign uir_pulse = uir_sync[SYNC_DEPTH-1] & ~uir_prev;

   assign cmd_valid = (level != '0);
   assign full      = (level == LW'(FIFO_DEPTH));
   assign pop       = cmd_valid & cmd_ready;
   // A pop frees the slot in the same cycle, so a capture landing on a full queue is kept.
   assign push      = udr_pulse & (~full | pop);
   assign drop      = udr_pulse & full & ~pop;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ir_in, sr};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         overflow       <= 1'b0;
         jdo            <= '0;
         pop_pend       <= 1'b0;
         pop_ir         <= '0;
         take_action    <= '0;
         take_no_action <= '0;
         ir_update      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         if (drop)              overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;

         pop_pend <= pop;
         if (pop) begin
            jdo    <= head[SR_W-1:0];
            pop_ir <= head[EW-1:SR_W];
         end

         // Decode a cycle after the pop, from the jdo that the pop just loaded.
         take_action    <= '0;
         take_no_action <= '0;
         if (pop_pend) begin
            if (jdo[ACT_BIT]) take_action[pop_ir]    <= 1'b1;
            else              take_no_action[pop_ir] <= 1'b1;
         end

         ir_update <= uir_pulse;
      end
   end
endmodule
